// File: rtl/irq_collector.sv
// irq_collector: gathers up to 16 level interrupt sources, latches them as
// pending with per-source mask and edge/level mode, and presents one combined
// request plus a 16-bit register file on an Avalon-MM slave.
module irq_collector #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq_out
);

    // Bits at and above NUM_SRC never hold state and always read as zero.
    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    localparam logic [2:0] A_PENDING = 3'd0;
    localparam logic [2:0] A_MASK    = 3'd1;
    localparam logic [2:0] A_MODE    = 3'd2;
    localparam logic [2:0] A_ACTIVE  = 3'd3;
    localparam logic [2:0] A_VECTOR  = 3'd4;
    localparam logic [2:0] A_RAW     = 3'd5;
    localparam logic [2:0] A_MISSED  = 3'd6;

    // Missed-event counter sticks at full scale instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] irq_ext;
    logic [15:0] sync1, sync2, prev;
    logic [15:0] pending, mask, mode, missed;
    logic        wr_en;
    logic [15:0] w1c, rise, set_vec, active, vector, rd_mux;
    logic        missed_evt;
    logic [3:0]  low_idx;

    // Zero-extend the source vector to the full register width.
    always_comb begin
        irq_ext = '0;
        irq_ext[NUM_SRC-1:0] = irq_in;
    end

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= irq_ext;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Decode bus writes, set conditions and the missed-event strobe.
    always_comb begin
        wr_en      = chipselect && !write_n;
        w1c        = (wr_en && address == A_PENDING) ? (writedata & SRC_MASK) : '0;
        rise       = sync2 & ~prev;
        set_vec    = ((mode & rise) | (~mode & sync2)) & SRC_MASK;
        missed_evt = |(mode & rise & pending & ~w1c);
        active     = pending & mask;
    end

    // Lowest-numbered active source wins the vector.
    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (active[i]) low_idx = 4'(i);
        end
        vector = (|active) ? {1'b1, 11'd0, low_idx} : 16'd0;
    end

    // Register file: pending (set beats clear), mask, mode, missed counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
            missed  <= '0;
        end else begin
            pending <= set_vec | (pending & ~w1c);
            if (wr_en && address == A_MASK) mask <= writedata & SRC_MASK;
            if (wr_en && address == A_MODE) mode <= writedata & SRC_MASK;
            if (wr_en && address == A_MISSED) missed <= '0;
            else if (missed_evt)              missed <= sat_inc(missed);
        end
    end

    // Read multiplexer, independent of chipselect.
    always_comb begin
        rd_mux = '0;
        case (address)
            A_PENDING: rd_mux = pending;
            A_MASK:    rd_mux = mask;
            A_MODE:    rd_mux = mode;
            A_ACTIVE:  rd_mux = active;
            A_VECTOR:  rd_mux = vector;
            A_RAW:     rd_mux = sync2;
            A_MISSED:  rd_mux = missed;
            default:   rd_mux = '0;
        endcase
    end

    // Registered read data and combined CPU request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq_out  <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq_out  <= |active;
        end
    end

endmodule

// File: tb/tb_irq_collector.sv
// Bench for irq_collector: a per-source behavioural model driven by a history
// of sampled inputs, checked against the DUT every cycle, plus directed reads
// with hand-computed values.
module tb_irq_collector;

    localparam int NUM_SRC = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [2:0]         address = '0;
    logic               chipselect = 1'b0;
    logic               write_n = 1'b1;
    logic [15:0]        writedata = '0;
    logic [15:0]        readdata;
    logic [NUM_SRC-1:0] irq_in = '0;
    logic               irq_out;

    int total = 0;
    int bad = 0;

    irq_collector #(.NUM_SRC(NUM_SRC)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq_in(irq_in), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_pend[16];
    int          m_mask[16];
    int          m_mode[16];
    int          m_missed;
    logic [15:0] h1, h2, h3;        // input as sampled 1, 2, 3 edges ago
    logic [15:0] exp_rd;
    logic        exp_irq;

    function automatic logic [15:0] to_vec(input int a[16]);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) if (a[i] != 0) v[i] = 1'b1;
        return v;
    endfunction

    function logic [15:0] model_read(input logic [2:0] a);
        logic [15:0] v;
        v = '0;
        case (a)
            3'd0: v = to_vec(m_pend);
            3'd1: v = to_vec(m_mask);
            3'd2: v = to_vec(m_mode);
            3'd3: for (int i = 0; i < NUM_SRC; i++) v[i] = (m_pend[i] != 0) && (m_mask[i] != 0);
            3'd4: begin
                for (int i = NUM_SRC - 1; i >= 0; i--)
                    if (m_pend[i] != 0 && m_mask[i] != 0) v = 16'h8000 + 16'(i);
            end
            3'd5: v = h2;
            3'd6: v = 16'(m_missed);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_pend[i] = 0; m_mask[i] = 0; m_mode[i] = 0;
        end
        m_missed = 0; h1 = '0; h2 = '0; h3 = '0; exp_rd = '0; exp_irq = 1'b0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_clear();
            end else begin
                logic wr, hit, clr, rs, st;
                exp_rd  = model_read(address);
                exp_irq = 1'b0;
                for (int i = 0; i < NUM_SRC; i++)
                    if (m_pend[i] != 0 && m_mask[i] != 0) exp_irq = 1'b1;
                wr  = chipselect && !write_n;
                hit = 1'b0;
                for (int i = 0; i < NUM_SRC; i++) begin
                    clr = wr && address == 3'd0 && writedata[i];
                    rs  = h2[i] && !h3[i];
                    st  = (m_mode[i] != 0) ? rs : h2[i];
                    if (m_mode[i] != 0 && rs && m_pend[i] != 0 && !clr) hit = 1'b1;
                    m_pend[i] = (st || (m_pend[i] != 0 && !clr)) ? 1 : 0;
                end
                if (wr && address == 3'd6) m_missed = 0;
                else if (hit && m_missed < 65535) m_missed = m_missed + 1;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (wr && address == 3'd1) m_mask[i] = writedata[i] ? 1 : 0;
                    if (wr && address == 3'd2) m_mode[i] = writedata[i] ? 1 : 0;
                end
                h3 = h2;
                h2 = h1;
                h1 = '0;
                h1[NUM_SRC-1:0] = irq_in;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            total++;
            if (readdata !== exp_rd) begin
                bad++;
                $display("FAIL cyc_readdata t=%0t: got %h want %h", $time, readdata, exp_rd);
            end
            total++;
            if (irq_out !== exp_irq) begin
                bad++;
                $display("FAIL cyc_irq_out t=%0t: got %b want %b", $time, irq_out, exp_irq);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wreg(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #2;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #2;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rchk(input logic [2:0] a, input logic [15:0] e, input string nm);
        @(posedge clk); #2;
        address = a;
        @(posedge clk); #3;
        lit(nm, readdata, e);
    endtask

    task automatic pulse(input int s);
        @(posedge clk); #2 irq_in[s] = 1'b1;
        @(posedge clk); #2 irq_in[s] = 1'b0;
        tick(3);
    endtask

    // Raise source s so its edge is detected on the same clock that samples the write.
    task automatic edge_with_write(input int s, input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #2 irq_in[s] = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #2;
        chipselect = 1'b0; write_n = 1'b1; irq_in[s] = 1'b0;
        tick(3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        tick(3); #2 reset_n = 1'b1;
        rchk(3'd1, 16'h0000, "reset_mask");
        rchk(3'd6, 16'h0000, "reset_missed");

        // Edge latency on source 1
        wreg(3'd1, 16'h0002);
        wreg(3'd2, 16'h0002);
        rchk(3'd0, 16'h0000, "edge_pend_idle");
        @(posedge clk); #2 irq_in[1] = 1'b1;
        @(posedge clk);                   // N
        @(posedge clk);                   // N+1
        @(posedge clk); #3;               // N+2
        lit("edge_irq_n2", {15'd0, irq_out}, 16'h0000);
        @(posedge clk); #3;               // N+3
        lit("edge_pend_n2", readdata, 16'h0002);
        lit("edge_irq_n3", {15'd0, irq_out}, 16'h0001);
        rchk(3'd4, 16'h8001, "edge_vector");
        wreg(3'd0, 16'h0002);
        rchk(3'd0, 16'h0000, "edge_w1c_held_high");
        @(posedge clk); #2 irq_in[1] = 1'b0;
        tick(3);

        // Level re-assert on source 0
        wreg(3'd2, 16'h0000);
        wreg(3'd1, 16'h0001);
        @(posedge clk); #2 irq_in[0] = 1'b1;
        tick(4);
        wreg(3'd0, 16'h0001);
        rchk(3'd0, 16'h0001, "level_set_wins");
        rchk(3'd5, 16'h0001, "raw_level");
        @(posedge clk); #2 irq_in[0] = 1'b0;
        tick(3);
        wreg(3'd0, 16'h0001);
        @(posedge clk); #3;
        lit("level_irq_drop", {15'd0, irq_out}, 16'h0000);
        rchk(3'd0, 16'h0000, "level_cleared");

        // Priority among sources 3 and 6
        wreg(3'd1, 16'h0048);
        @(posedge clk); #2 irq_in[3] = 1'b1; irq_in[6] = 1'b1;
        tick(4);
        rchk(3'd4, 16'h8003, "prio_vec_3");
        wreg(3'd1, 16'h0040);
        rchk(3'd4, 16'h8006, "prio_vec_6");
        rchk(3'd3, 16'h0040, "prio_active");
        wreg(3'd1, 16'hFFFF);
        rchk(3'd1, 16'h00FF, "mask_upper_ignored");
        rchk(3'd7, 16'h0000, "addr7_zero");
        @(posedge clk); #2 irq_in = '0;
        tick(4);
        wreg(3'd0, 16'hFFFF);
        rchk(3'd0, 16'h0000, "prio_cleared");

        // Missed counting on edge-mode source 0
        wreg(3'd1, 16'h0001);
        wreg(3'd2, 16'h0001);
        pulse(0);
        rchk(3'd0, 16'h0001, "missed_first_sets");
        for (int k = 0; k < 5; k++) pulse(0);
        rchk(3'd6, 16'h0005, "missed_five");
        edge_with_write(0, 3'd6, 16'h0000);
        rchk(3'd6, 16'h0000, "missed_clear_wins");

        // W1C coinciding with a new edge on source 2
        wreg(3'd2, 16'h0005);
        pulse(2);
        pulse(0);
        rchk(3'd6, 16'h0001, "simul_pre_missed");
        edge_with_write(2, 3'd0, 16'h0004);
        rchk(3'd0, 16'h0005, "simul_pend_kept");
        rchk(3'd6, 16'h0001, "simul_missed_same");
        pulse(0);
        pulse(0);
        rchk(3'd6, 16'h0003, "pre_reset_missed");
        rchk(3'd0, 16'h0005, "pre_reset_pend");

        // Asynchronous reset mid-run
        @(posedge clk); #4 reset_n = 1'b0;
        #1;
        lit("rst_irq_out", {15'd0, irq_out}, 16'h0000);
        lit("rst_readdata", readdata, 16'h0000);
        tick(2); #2 reset_n = 1'b1;
        for (int a = 0; a < 7; a++) rchk(3'(a), 16'h0000, "post_reset_read");

        // Saturation: two staggered edge sources give one missed event per clock
        wreg(3'd2, 16'h0003);
        wreg(3'd1, 16'h0003);
        @(posedge clk); #2 irq_in[1:0] = 2'b01;
        repeat (65545) begin
            @(posedge clk); #2 irq_in[1:0] = ~irq_in[1:0];
        end
        irq_in = '0;
        tick(4);
        rchk(3'd6, 16'hFFFF, "missed_saturated");
        wreg(3'd6, 16'h1234);
        rchk(3'd6, 16'h0000, "missed_write_clears");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
